// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin sharing of one single-port register file
// between two requesters (A = index 0, B = index 1). A granted request is
// latched and turned into a chip-select / output-enable / write-strobe
// sequence: IDLE -> SETUP -> STROBE -> DONE. Every register file control
// pin comes straight from a flop.
module regfile_arbiter #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0]       req_i,
    input  logic [1:0]       we_i,
    input  logic [Depth-1:0] addr_a_i,
    input  logic [Depth-1:0] addr_b_i,
    input  logic [Width-1:0] wdata_a_i,
    input  logic [Width-1:0] wdata_b_i,
    output logic [1:0]       ack_o,
    output logic [Width-1:0] rdata_o,
    output logic             cs_no,
    output logic             oe_o,
    output logic             ws_o,
    output logic [Depth-1:0] addr_o,
    output logic [Width-1:0] data_o,
    input  logic [Width-1:0] data_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    // r_last: requester granted most recently (1 = B), so A wins the first tie
    logic             r_last;
    logic             r_gnt;
    logic             r_we;
    logic [Depth-1:0] r_addr;
    logic [Width-1:0] r_wdata;
    logic [Width-1:0] r_rdata;
    logic             r_cs_n;
    logic             r_oe;
    logic             r_ws;
    logic [1:0]       r_ack;

    logic             w_start;
    logic             w_sel;
    logic             w_sel_we;
    logic [Depth-1:0] w_sel_addr;
    logic [Width-1:0] w_sel_wdata;
    logic             w_cur_we;
    logic             w_cs_n;
    logic             w_oe;
    logic             w_ws;
    logic [1:0]       w_ack;

    // A new access starts only from IDLE; requests at other times wait
    assign w_start = (r_state == ST_IDLE) && (req_i != 2'b00);

    // Round-robin winner selection and mux of the winner's request fields
    always_comb begin
        w_sel = 1'b0;
        case (req_i)
            2'b01:   w_sel = 1'b0;
            2'b10:   w_sel = 1'b1;
            2'b11:   w_sel = ~r_last;
            default: w_sel = 1'b0;
        endcase
        if (w_sel) begin
            w_sel_we    = we_i[1];
            w_sel_addr  = addr_b_i;
            w_sel_wdata = wdata_b_i;
        end else begin
            w_sel_we    = we_i[0];
            w_sel_addr  = addr_a_i;
            w_sel_wdata = wdata_a_i;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: only IDLE waits, the rest of the sequence is fixed
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next_state = ST_SETUP;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SETUP:  w_next_state = ST_STROBE;
            ST_STROBE: w_next_state = ST_DONE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Output decode for the state being entered, so the pins can be registered
    always_comb begin
        w_cur_we = r_we;
        if (w_start) begin
            w_cur_we = w_sel_we;
        end else begin
            w_cur_we = r_we;
        end
        w_cs_n = 1'b1;
        w_oe   = 1'b0;
        w_ws   = 1'b0;
        w_ack  = 2'b00;
        case (w_next_state)
            ST_IDLE: begin
                w_cs_n = 1'b1;
                w_oe   = 1'b0;
                w_ws   = 1'b0;
                w_ack  = 2'b00;
            end
            ST_SETUP: begin
                w_cs_n = 1'b0;
                w_oe   = ~w_cur_we;
                w_ws   = 1'b0;
                w_ack  = 2'b00;
            end
            ST_STROBE: begin
                w_cs_n = 1'b0;
                w_oe   = ~r_we;
                w_ws   = r_we;
                w_ack  = 2'b00;
            end
            ST_DONE: begin
                w_cs_n = 1'b0;
                w_oe   = r_oe;
                w_ws   = 1'b0;
                if (r_gnt) begin
                    w_ack = 2'b10;
                end else begin
                    w_ack = 2'b01;
                end
            end
            default: begin
                w_cs_n = 1'b1;
                w_oe   = 1'b0;
                w_ws   = 1'b0;
                w_ack  = 2'b00;
            end
        endcase
    end

    // Latch the winner's request and remember it for the next tie-break
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last  <= 1'b1;
            r_gnt   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= {Depth{1'b0}};
            r_wdata <= {Width{1'b0}};
        end else if (w_start) begin
            r_last  <= w_sel;
            r_gnt   <= w_sel;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
        end else begin
            r_last  <= r_last;
            r_gnt   <= r_gnt;
            r_we    <= r_we;
            r_addr  <= r_addr;
            r_wdata <= r_wdata;
        end
    end

    // Registered register-file control pins and acknowledge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cs_n <= 1'b1;
            r_oe   <= 1'b0;
            r_ws   <= 1'b0;
            r_ack  <= 2'b00;
        end else begin
            r_cs_n <= w_cs_n;
            r_oe   <= w_oe;
            r_ws   <= w_ws;
            r_ack  <= w_ack;
        end
    end

    // Capture read data as the strobe phase ends; held until the next read
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata <= {Width{1'b0}};
        end else if ((r_state == ST_STROBE) && !r_we) begin
            r_rdata <= data_i;
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign ack_o   = r_ack;
    assign rdata_o = r_rdata;
    assign cs_no   = r_cs_n;
    assign oe_o    = r_oe;
    assign ws_o    = r_ws;
    assign addr_o  = r_addr;
    assign data_o  = r_wdata;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Testbench for regfile_arbiter: a behavioural register file is attached to
// the control pins, and each scenario task compares the DUT against a
// word-level memory image and a round-robin grant model.
module tb_regfile_arbiter;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic [1:0] req_i;
    logic [1:0] we_i;
    logic [3:0] addr_a_i;
    logic [3:0] addr_b_i;
    logic [7:0] wdata_a_i;
    logic [7:0] wdata_b_i;
    logic [1:0] ack_o;
    logic [7:0] rdata_o;
    logic       cs_no;
    logic       oe_o;
    logic       ws_o;
    logic [3:0] addr_o;
    logic [7:0] data_o;
    logic [7:0] data_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: memory image, last granted requester, held read data
    logic [7:0] exp_mem [16] = '{default: 8'h00};
    logic       m_last  = 1'b1;
    logic [7:0] m_rdata = 8'h00;

    // Register file model: writes on the rising edge of the strobe
    logic [7:0] rf [16] = '{default: 8'h00};
    int         ws_edges = 0;
    logic [3:0] ws_addr  = 4'h0;
    logic [7:0] ws_data  = 8'h00;

    regfile_arbiter #(.Width(8), .Depth(4)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_a_i  (addr_a_i),
        .addr_b_i  (addr_b_i),
        .wdata_a_i (wdata_a_i),
        .wdata_b_i (wdata_b_i),
        .ack_o     (ack_o),
        .rdata_o   (rdata_o),
        .cs_no     (cs_no),
        .oe_o      (oe_o),
        .ws_o      (ws_o),
        .addr_o    (addr_o),
        .data_o    (data_o),
        .data_i    (data_i)
    );

    always #5 clk = ~clk;

    always @(posedge ws_o) begin
        rf[addr_o] = data_o;
        ws_edges   = ws_edges + 1;
        ws_addr    = addr_o;
        ws_data    = data_o;
    end

    assign data_i = rf[addr_o];

    // Issue one request pattern and wait (bounded) for its acknowledge.
    // Called and returns at 1 time unit after a rising edge with the DUT idle.
    task automatic run_req(input logic [1:0] req, input logic [1:0] we,
                           input logic [3:0] aa, input logic [3:0] ab,
                           input logic [7:0] da, input logic [7:0] db,
                           output int lat, output logic [1:0] ack,
                           output logic [7:0] rd, output int ws_cyc);
        req_i = req; we_i = we; addr_a_i = aa; addr_b_i = ab;
        wdata_a_i = da; wdata_b_i = db;
        lat = -1; ack = 2'b00; rd = 8'h00; ws_cyc = -1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (ws_o === 1'b1 && ws_cyc < 0) ws_cyc = c;
            if (ack_o !== 2'b00) begin
                lat = c; ack = ack_o; rd = rdata_o;
                break;
            end
        end
        req_i = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        req_i = 2'b00;
        rst_ni = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;
        m_last  = 1'b1;
        m_rdata = 8'h00;
    endtask

    task automatic test_reset();
        rst_ni = 1'b1; req_i = 2'b11; we_i = 2'b11;
        addr_a_i = 4'h1; addr_b_i = 4'h2; wdata_a_i = 8'h11; wdata_b_i = 8'h22;
        #2 rst_ni = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({cs_no, oe_o, ws_o, ack_o} !== 5'b10000)
                $display("FAIL reset_pins cycle %0d: got cs/oe/ws/ack=%b, want 10000",
                         c, {cs_no, oe_o, ws_o, ack_o});
            else n_pass++;
        end
        n_checks++;
        if ({rdata_o, addr_o, data_o} !== 20'h0)
            $display("FAIL reset_data: got rdata/addr/data=%h, want 0", {rdata_o, addr_o, data_o});
        else n_pass++;
        req_i = 2'b00;
        rst_ni = 1'b1;
        @(posedge clk); #1;
        m_last = 1'b1;
    endtask

    task automatic test_write_read_a();
        int lat; int wc; int e0; logic [1:0] ack; logic [7:0] rd;
        e0 = ws_edges;
        run_req(2'b01, 2'b01, 4'd3, 4'd0, 8'hA5, 8'h00, lat, ack, rd, wc);
        exp_mem[3] = 8'hA5; m_last = 1'b0;
        n_checks++;
        if (lat !== 3 || ack !== 2'b01)
            $display("FAIL wr_a_ack: got lat=%0d ack=%b, want lat=3 ack=01", lat, ack);
        else n_pass++;
        n_checks++;
        if (wc !== 2 || ws_edges - e0 !== 1)
            $display("FAIL wr_a_strobe: got ws cycle=%0d edges=%0d, want 2 and 1", wc, ws_edges - e0);
        else n_pass++;
        n_checks++;
        if (ws_addr !== 4'd3 || ws_data !== 8'hA5)
            $display("FAIL wr_a_bus: got addr=%h data=%h, want 3 a5", ws_addr, ws_data);
        else n_pass++;
        e0 = ws_edges;
        run_req(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00, lat, ack, rd, wc);
        n_checks++;
        if (lat !== 3 || ack !== 2'b01 || rd !== 8'hA5)
            $display("FAIL rd_a: got lat=%0d ack=%b rdata=%h, want 3 01 a5", lat, ack, rd);
        else n_pass++;
        n_checks++;
        if (ws_edges - e0 !== 0)
            $display("FAIL rd_a_nostrobe: got %0d strobes, want 0", ws_edges - e0);
        else n_pass++;
    endtask

    task automatic test_contention();
        int         cyc_q[$];
        logic [1:0] ack_q[$];
        logic       g;
        do_reset();
        req_i = 2'b11; we_i = 2'b00; addr_a_i = 4'd3; addr_b_i = 4'd7;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (ack_o !== 2'b00) begin
                cyc_q.push_back(c);
                ack_q.push_back(ack_o);
            end
        end
        req_i = 2'b00;
        repeat (4) begin @(posedge clk); #1; end
        n_checks++;
        if (cyc_q.size() !== 4)
            $display("FAIL contention_count: got %0d acks, want 4", cyc_q.size());
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            g = ~m_last; m_last = g;
            if (k < cyc_q.size()) begin
                n_checks++;
                if (cyc_q[k] !== 3 + 4 * k || ack_q[k] !== (g ? 2'b10 : 2'b01))
                    $display("FAIL contention_grant%0d: got cycle=%0d ack=%b, want cycle=%0d ack=%b",
                             k, cyc_q[k], ack_q[k], 3 + 4 * k, (g ? 2'b10 : 2'b01));
                else n_pass++;
            end
        end
    endtask

    task automatic test_input_stability();
        int lat; int wc; int e0; logic [1:0] ack; logic [7:0] rd;
        e0 = ws_edges; lat = -1; ack = 2'b00;
        req_i = 2'b10; we_i = 2'b10; addr_b_i = 4'd7; wdata_b_i = 8'h3C;
        @(posedge clk); #1;
        wdata_b_i = 8'hFF;
        for (int c = 2; c <= 8; c++) begin
            @(posedge clk); #1;
            if (ack_o !== 2'b00) begin lat = c; ack = ack_o; break; end
        end
        req_i = 2'b00;
        @(posedge clk); #1;
        exp_mem[7] = 8'h3C; m_last = 1'b1;
        n_checks++;
        if (lat !== 3 || ack !== 2'b10)
            $display("FAIL stab_ack: got lat=%0d ack=%b, want 3 10", lat, ack);
        else n_pass++;
        n_checks++;
        if (ws_edges - e0 !== 1 || ws_data !== 8'h3C || ws_addr !== 4'd7)
            $display("FAIL stab_write: got edges=%0d addr=%h data=%h, want 1 7 3c",
                     ws_edges - e0, ws_addr, ws_data);
        else n_pass++;
        run_req(2'b10, 2'b00, 4'd0, 4'd7, 8'h00, 8'h00, lat, ack, rd, wc);
        n_checks++;
        if (ack !== 2'b10 || rd !== exp_mem[7])
            $display("FAIL stab_read: got ack=%b rdata=%h, want 10 %h", ack, rd, exp_mem[7]);
        else n_pass++;
    endtask

    task automatic test_reset_in_setup();
        int lat; int wc; int e0; logic [1:0] ack; logic [7:0] rd;
        logic saw_ack; logic saw_ws;
        run_req(2'b01, 2'b01, 4'd2, 4'd0, 8'h5A, 8'h00, lat, ack, rd, wc);
        exp_mem[2] = 8'h5A;
        e0 = ws_edges; saw_ack = 1'b0; saw_ws = 1'b0;
        req_i = 2'b01; we_i = 2'b01; addr_a_i = 4'd2; wdata_a_i = 8'h99;
        @(posedge clk); #1;
        n_checks++;
        if (cs_no !== 1'b0 || oe_o !== 1'b0)
            $display("FAIL rs_setup_entered: got cs_no=%b oe=%b, want 0 0", cs_no, oe_o);
        else n_pass++;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (cs_no !== 1'b1)
            $display("FAIL rs_async: got cs_no=%b, want 1", cs_no);
        else n_pass++;
        req_i = 2'b00;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (ack_o !== 2'b00) saw_ack = 1'b1;
            if (ws_o !== 1'b0) saw_ws = 1'b1;
        end
        rst_ni = 1'b1;
        m_last = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (saw_ack || saw_ws || ws_edges - e0 !== 0)
            $display("FAIL rs_abandon: got ack=%b ws=%b edges=%0d, want 0 0 0",
                     saw_ack, saw_ws, ws_edges - e0);
        else n_pass++;
        run_req(2'b01, 2'b00, 4'd2, 4'd0, 8'h00, 8'h00, lat, ack, rd, wc);
        m_last = 1'b0;
        n_checks++;
        if (ack !== 2'b01 || rd !== 8'h5A)
            $display("FAIL rs_keep: got ack=%b rdata=%h, want 01 5a", ack, rd);
        else n_pass++;
    endtask

    task automatic test_boundary();
        int lat; int wc; logic [1:0] ack; logic [7:0] rd; logic [7:0] d;
        d = 8'($urandom);
        run_req(2'b01, 2'b01, 4'd15, 4'd0, d, 8'h00, lat, ack, rd, wc);
        exp_mem[15] = d;
        run_req(2'b10, 2'b10, 4'd0, 4'd0, 8'h00, ~d, lat, ack, rd, wc);
        exp_mem[0] = ~d;
        run_req(2'b10, 2'b00, 4'd0, 4'd15, 8'h00, 8'h00, lat, ack, rd, wc);
        n_checks++;
        if (rd !== exp_mem[15])
            $display("FAIL boundary_15: got %h, want %h", rd, exp_mem[15]);
        else n_pass++;
        run_req(2'b01, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, lat, ack, rd, wc);
        n_checks++;
        if (rd !== exp_mem[0])
            $display("FAIL boundary_0: got %h, want %h", rd, exp_mem[0]);
        else n_pass++;
    endtask

    task automatic test_random();
        int lat; int wc; int e0; logic [1:0] ack; logic [7:0] rd;
        logic [1:0] req; logic [1:0] we; logic [3:0] aa; logic [3:0] ab;
        logic [7:0] da; logic [7:0] db;
        logic g; logic [3:0] ga; logic [7:0] gd; logic [7:0] exp_rd;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            req = 2'($urandom_range(1, 3)); we = 2'($urandom);
            aa = 4'($urandom); ab = 4'($urandom);
            da = 8'($urandom); db = 8'($urandom);
            if (req == 2'b01)      g = 1'b0;
            else if (req == 2'b10) g = 1'b1;
            else                   g = ~m_last;
            m_last = g;
            ga = g ? ab : aa;
            gd = g ? db : da;
            e0 = ws_edges;
            run_req(req, we, aa, ab, da, db, lat, ack, rd, wc);
            if (we[g]) begin
                exp_mem[ga] = gd;
                exp_rd = m_rdata;
            end else begin
                exp_rd  = exp_mem[ga];
                m_rdata = exp_rd;
            end
            n_checks++;
            if (ack !== (g ? 2'b10 : 2'b01) || lat !== 3)
                $display("FAIL rand%0d_grant: got ack=%b lat=%0d, want %b 3",
                         it, ack, lat, (g ? 2'b10 : 2'b01));
            else n_pass++;
            n_checks++;
            if (rd !== exp_rd)
                $display("FAIL rand%0d_rdata: got %h, want %h", it, rd, exp_rd);
            else n_pass++;
            n_checks++;
            if (ws_edges - e0 !== (we[g] ? 1 : 0))
                $display("FAIL rand%0d_strobes: got %0d, want %0d", it, ws_edges - e0, (we[g] ? 1 : 0));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read_a();
        test_contention();
        test_input_stability();
        test_reset_in_setup();
        test_boundary();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
